multdiv_issue_checker: RTL
==========================

Name: multdiv_issue_checker

Overview:
- Initiator side of the multdiv handshake. Accepts one mult/div request at a time from the pipeline and drives the multdiv control and operand lines.
- Waits for the result handshake, with a timeout, and checks the returned result with a mod-3 residue code to detect injected or real faults.
- Reports the result with a fault flag and keeps a saturating fault counter for the fault-detection logic.

Parameters:
- TIMEOUT_CYCLES, 64: number of WAIT cycles without md_resultRDY before a timeout is declared (must be at least 2).
- CNT_W, 16: width of fault_count.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_op  in  1  0 = mult, 1 = div.
- req_a  in  32  signed operand A.
- req_b  in  16  signed operand B.
- req_ready  out  1  request accepted on req_valid & req_ready.
- md_operandA  out  32  to multdiv data_operandA.
- md_operandB  out  16  to multdiv data_operandB.
- md_ctrl_MULT  out  1  mult select, level.
- md_ctrl_DIV  out  1  div select, level.
- md_result  in  32  multdiv data_result (product or quotient).
- md_remainder  in  32  multdiv out_remainder.
- md_exception  in  1  multdiv data_exception.
- md_inputRDY  in  1  multdiv data_inputRDY.
- md_resultRDY  in  1  multdiv data_resultRDY.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response accepted on rsp_valid & rsp_ready.
- rsp_result  out  32  captured product or quotient.
- rsp_remainder  out  32  captured remainder; 0 for mult.
- rsp_exception  out  1  overflow or divide-by-zero.
- rsp_fault  out  1  residue mismatch or timeout.
- rsp_timeout  out  1  timeout occurred.
- fault_count  out  CNT_W  saturating count of responses with rsp_fault = 1.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0 except req_ready = 1; operand registers 0; fault_count 0. Reset mid-operation drops ctrl immediately, abandons the operation and produces no response.
- FSM states: IDLE, WAIT, CHECK, RESP.
- IDLE:
  - req_ready = md_inputRDY.
  - On accept: latch op, A and B onto md_operand*; go to WAIT next cycle.
- WAIT:
  - The ctrl line for the op (MULT or DIV) is held high for every WAIT cycle. The multdiv output mux is level-selected by ctrl, so ctrl must stay asserted through capture.
  - Timeout counter starts at 0 on entry and increments each WAIT cycle.
  - Priority: md_exception > md_resultRDY > timeout.
  - md_exception = 1 (div by B = 0, or mult overflow): capture rsp_exception = 1, result 0, remainder 0, fault 0; go to RESP.
  - md_resultRDY = 1: capture md_result; capture md_remainder for div, 0 for mult; go to CHECK.
  - Counter reaches TIMEOUT_CYCLES-1 with neither event: rsp_timeout = 1, rsp_fault = 1, result 0; go to RESP.
  - ctrl drops on the cycle after capture.
- CHECK (one cycle, ctrl low). Signed residue: r(x) = (unsigned_pattern(x) mod 3 − sign(x)) mod 3, valid because 2^32 ≡ 2^16 ≡ 1 (mod 3).
  - mult: fault = r(A)·r(B) mod 3 ≠ r(P).
  - div: fault = (r(Q)·r(B) + r(R)) mod 3 ≠ r(A). Uses truncating division; R takes the sign of A.
  - Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* outputs stable until rsp_ready.
  - fault_count increments (saturating at all-ones) exactly once, on the cycle RESP is entered with rsp_fault = 1.
  - On rsp_ready: clear rsp_valid and go to IDLE. A new request may be accepted in the following cycle (no same-cycle bypass).
- Latency, accept to rsp_valid: N + 2 cycles, where N = WAIT cycles until resultRDY (N ≥ 1). Exception and timeout paths: N + 1.
- req_ready = 0 outside IDLE. rsp_valid = 0 outside RESP.
- md_resultRDY or md_exception while not in WAIT: ignored.

Decomposition:
- Package multdiv_chk_pkg:
  - state enum (IDLE/WAIT/CHECK/RESP)
  - OP_MULT = 0, OP_DIV = 1
  - residue width = 2
- Sub-module mod3_residue (parameter WIDTH, signed input, 2-bit output):
  - sums 2-bit groups (4 ≡ 1 mod 3), folds the sum to 0..2, then subtracts the sign bit mod 3.
  - Instantiated for A, B, result and remainder.

Test Plan:
- Mult 7 × −3, model returns −21 after 5 cycles → rsp_result = 0xFFFFFFEB, fault 0, exception 0, rsp_valid 7 cycles after accept; md_ctrl_MULT high exactly 5 cycles.
- Div 100 / 7, model returns Q = 14, R = 2 → result 14, remainder 2, fault 0. Then −100 / 7 with Q = −14, R = −2 → fault 0.
- Fault injection: mult 7 × 3 with model returning 22 → rsp_fault 1, fault_count 1. Div 100 / 7 returning Q = 15, R = 2 → fault_count 2.
- Div by B = 0, model asserts md_exception in the first WAIT cycle → rsp_exception 1, result 0, fault 0, fault_count unchanged.
- Model never asserts resultRDY, TIMEOUT_CYCLES = 8 → after 8 WAIT cycles rsp_timeout = 1, rsp_fault = 1; ctrl low afterwards.
- Backpressure: rsp_ready low for 4 cycles → outputs stable and req_ready 0 throughout. Reset asserted during WAIT → ctrl low immediately, no rsp_valid, fault_count 0.

Source files
------------

// File: rtl/multdiv_issue_checker_pkg.sv
// multdiv_chk_pkg: shared types and residue helpers for the multdiv issue checker
package multdiv_chk_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, CHECK, RESP} state_t;
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam int RES_W = 2;
    typedef logic [RES_W-1:0] res_t;
    function automatic res_t mod3_fold(input logic [3:0] v);
        logic [3:0] t;
        t = v % 4'd3;
        return t[RES_W-1:0];
    endfunction
endpackage

// File: rtl/multdiv_issue_checker_if.sv
// multdiv_issue_checker_if: request, multdiv and response lines of the issue checker
interface multdiv_issue_checker_if;
    logic req_valid;
    logic req_op;
    logic signed [31:0] req_a;
    logic signed [15:0] req_b;
    logic req_ready;
    logic [31:0] md_operandA;
    logic [15:0] md_operandB;
    logic md_ctrl_MULT;
    logic md_ctrl_DIV;
    logic [31:0] md_result;
    logic [31:0] md_remainder;
    logic md_exception;
    logic md_inputRDY;
    logic md_resultRDY;
    logic rsp_valid;
    logic rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] rsp_remainder;
    logic rsp_exception;
    logic rsp_fault;
    logic rsp_timeout;
    modport master (
        input req_valid, req_op, req_a, req_b, md_result, md_remainder, md_exception,
              md_inputRDY, md_resultRDY, rsp_ready,
        output req_ready, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
               rsp_valid, rsp_result, rsp_remainder, rsp_exception, rsp_fault, rsp_timeout
    );
    modport slave (
        output req_valid, req_op, req_a, req_b, md_result, md_remainder, md_exception,
               md_inputRDY, md_resultRDY, rsp_ready,
        input req_ready, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
              rsp_valid, rsp_result, rsp_remainder, rsp_exception, rsp_fault, rsp_timeout
    );
endinterface

// File: rtl/mod3_residue.sv
// mod3_residue: signed value modulo 3, using 4 = 1 (mod 3) and 2^WIDTH = 1 (mod 3) for even WIDTH
module mod3_residue
    import multdiv_chk_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic signed [WIDTH-1:0] x,
    output res_t r
);
    localparam int PW = WIDTH + WIDTH % 2;
    localparam int N = PW / 2;
    localparam int SW = $clog2(3 * N + 1) < 2 ? 2 : $clog2(3 * N + 1);
    logic [PW-1:0] u;
    logic [SW-1:0] sum, f;
    res_t m;
    assign u = PW'($unsigned(x));
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) sum = sum + SW'(u[2*i +: 2]);
        f = sum;
        for (int i = 0; i < SW; i++) f = SW'(f[1:0]) + (f >> 2);
        m = (f[1:0] == 2'd3) ? 2'd0 : f[1:0];
        r = !x[WIDTH-1] ? m : (m == 2'd0 ? 2'd2 : m - 2'd1);
    end
endmodule

// File: rtl/multdiv_issue_checker.sv
// multdiv_issue_checker: issues one mult/div to the multdiv unit, waits with timeout,
// and checks the returned result with a mod-3 residue code before responding
module multdiv_issue_checker
    import multdiv_chk_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W = 16
) (
    input logic clock,
    input logic reset,
    multdiv_issue_checker_if.master bus,
    output logic [CNT_W-1:0] fault_count
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    state_t state;
    logic op_q, rdy_q, fault_chk;
    logic [TW-1:0] cnt;
    res_t ra, rb, rq, rr;
    logic [3:0] mul_sum, div_sum;
    logic [CNT_W-1:0] cnt_inc;
    mod3_residue #(.WIDTH(32)) u_ra (.x(bus.md_operandA), .r(ra));
    mod3_residue #(.WIDTH(16)) u_rb (.x(bus.md_operandB), .r(rb));
    mod3_residue #(.WIDTH(32)) u_rq (.x(bus.rsp_result), .r(rq));
    mod3_residue #(.WIDTH(32)) u_rr (.x(bus.rsp_remainder), .r(rr));
    assign bus.req_ready = rdy_q & bus.md_inputRDY;
    assign mul_sum = {2'b0, ra} * {2'b0, rb};
    assign div_sum = {2'b0, rq} * {2'b0, rb} + {2'b0, rr};
    assign fault_chk = (op_q == OP_DIV) ? (mod3_fold(div_sum) != ra) : (mod3_fold(mul_sum) != rq);
    assign cnt_inc = &fault_count ? fault_count : fault_count + CNT_W'(1);
    // ctrl stays up through the capture cycle because the multdiv output mux is level-selected
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_q <= 1'b0;
            rdy_q <= 1'b1;
            cnt <= '0;
            bus.md_operandA <= '0;
            bus.md_operandB <= '0;
            bus.md_ctrl_MULT <= 1'b0;
            bus.md_ctrl_DIV <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_remainder <= '0;
            bus.rsp_exception <= 1'b0;
            bus.rsp_fault <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            fault_count <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid && bus.req_ready) begin
                    op_q <= bus.req_op;
                    bus.md_operandA <= bus.req_a;
                    bus.md_operandB <= bus.req_b;
                    bus.md_ctrl_MULT <= bus.req_op == OP_MULT;
                    bus.md_ctrl_DIV <= bus.req_op == OP_DIV;
                    cnt <= '0;
                    rdy_q <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.md_exception || bus.md_resultRDY || cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        bus.md_ctrl_MULT <= 1'b0;
                        bus.md_ctrl_DIV <= 1'b0;
                        bus.rsp_exception <= bus.md_exception;
                        bus.rsp_timeout <= !bus.md_exception && !bus.md_resultRDY;
                        bus.rsp_fault <= !bus.md_exception && !bus.md_resultRDY;
                        bus.rsp_result <= (!bus.md_exception && bus.md_resultRDY) ? bus.md_result : '0;
                        bus.rsp_remainder <= (!bus.md_exception && bus.md_resultRDY && op_q == OP_DIV) ?
                                             bus.md_remainder : '0;
                        bus.rsp_valid <= bus.md_exception || !bus.md_resultRDY;
                        state <= (!bus.md_exception && bus.md_resultRDY) ? CHECK : RESP;
                        if (!bus.md_exception && !bus.md_resultRDY) fault_count <= cnt_inc;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                CHECK: begin
                    bus.rsp_fault <= fault_chk;
                    bus.rsp_valid <= 1'b1;
                    if (fault_chk) fault_count <= cnt_inc;
                    state <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
